// File: rtl/uart_pkg.sv
// Shared types and default timing constants for the uart host controller.
package uart_pkg;

  // One clkin period of the uart core, measured in 100 MHz clk cycles.
  localparam int CLKIN_CYC      = 651;
  localparam int WRN_CYC_DEF    = 2 ** $clog2(CLKIN_CYC);
  localparam int RDN_CYC_DEF    = 2 ** $clog2(CLKIN_CYC);
  localparam int TX_TIMEOUT_DEF = 2 ** ($clog2(CLKIN_CYC) + 8) - 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_GRANT,
    TX_WR,
    TX_BUSY,
    TX_DONE
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RD,
    RX_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO holding bytes drained from the uart receiver.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         I_rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// Drives the uart core's wrn/rdn strobes: round-robin transmit for two requesters
// and an RX drain into a small FIFO, with t_empty/r_ready synchronised from clkin.
module uart_host_ctrl
  import uart_pkg::*;
#(
  parameter int WRN_CYC    = WRN_CYC_DEF,
  parameter int RDN_CYC    = RDN_CYC_DEF,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF,
  parameter int RXF_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       I_rst_n,
  // reqN_valid/reqN_data are held by the requester; reqN_ready pulses for exactly
  // the one cycle in which the byte is taken. Dropping valid earlier withdraws it.
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_pop,
  output logic       tx_err,
  output logic       rx_stall,
  output logic       u_wrn,
  output logic       u_rdn,
  output logic [7:0] u_d_in,
  input  logic [7:0] u_d_out,
  input  logic       u_t_empty,
  input  logic       u_r_ready,
  output logic [2:0] dbg_tx_state,
  output logic [1:0] dbg_rx_state
);

  localparam int TX_CW = $clog2(((WRN_CYC > TX_TIMEOUT) ? WRN_CYC : TX_TIMEOUT) + 1);
  localparam int RX_CW = $clog2(RDN_CYC + 1);

  logic [1:0] te_sync_q, rr_sync_q;
  logic       te_s, rr_s;

  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      te_sync_q <= '0;
      rr_sync_q <= '0;
    end else begin
      te_sync_q <= {te_sync_q[0], u_t_empty};
      rr_sync_q <= {rr_sync_q[0], u_r_ready};
    end
  end

  assign te_s = te_sync_q[1];
  assign rr_s = rr_sync_q[1];

  tx_state_e        tx_state_q, tx_state_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]       d_in_q, d_in_d;
  logic             last_q, last_d;  // 1: req1 was granted last, so req0 wins a tie
  logic             wrn_q, wrn_d, tx_err_q, tx_err_d;
  logic             grant0, grant1;

  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      d_in_q     <= '0;
      last_q     <= 1'b1;
      wrn_q      <= 1'b1;
      tx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      d_in_q     <= d_in_d;
      last_q     <= last_d;
      wrn_q      <= wrn_d;
      tx_err_q   <= tx_err_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    d_in_d     = d_in_q;
    last_d     = last_q;
    tx_err_d   = tx_err_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (te_s && (req0_valid || req1_valid)) tx_state_d = TX_GRANT;
      TX_GRANT: begin
        if (req0_valid && req1_valid) begin
          grant0 = last_q;
          grant1 = !last_q;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
        if (grant0 || grant1) begin
          d_in_d     = grant1 ? req1_data : req0_data;
          last_d     = grant1;
          tx_cnt_d   = '0;
          tx_state_d = TX_WR;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_WR: begin
        if (tx_cnt_q == TX_CW'(WRN_CYC - 1)) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_BUSY;
        end else begin
          tx_cnt_d = tx_cnt_q + TX_CW'(1);
        end
      end
      TX_BUSY: begin
        if (!te_s) begin
          tx_state_d = TX_DONE;
        end else if (tx_cnt_q == TX_CW'(TX_TIMEOUT - 1)) begin
          tx_err_d   = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + TX_CW'(1);
        end
      end
      TX_DONE: if (te_s) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    // Strobe is registered from the next state so it is glitch-free toward the uart.
    wrn_d = (tx_state_d != TX_WR);
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign u_d_in       = d_in_q;
  assign u_wrn        = wrn_q;
  assign tx_err       = tx_err_q;
  assign dbg_tx_state = tx_state_q;

  rx_state_e        rx_state_q, rx_state_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic             rdn_q, rdn_d;
  logic             fifo_push, fifo_empty, fifo_full;

  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rdn_q      <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rdn_q      <= rdn_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    fifo_push  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rr_s && !fifo_full) begin
          fifo_push  = 1'b1;
          rx_cnt_d   = '0;
          rx_state_d = RX_RD;
        end
      end
      RX_RD: begin
        if (rx_cnt_q == RX_CW'(RDN_CYC - 1)) rx_state_d = RX_WAIT;
        else rx_cnt_d = rx_cnt_q + RX_CW'(1);
      end
      // Hold off until r_ready falls so one byte is never captured twice.
      RX_WAIT: if (!rr_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
    rdn_d = (rx_state_d != RX_RD);
  end

  assign rx_stall     = (rx_state_q == RX_IDLE) && rr_s && fifo_full;
  assign u_rdn        = rdn_q;
  assign rx_valid     = !fifo_empty;
  assign dbg_rx_state = rx_state_q;

  uart_rx_fifo #(
    .DEPTH(RXF_DEPTH),
    .W    (8)
  ) u_rx_fifo (
    .clk    (clk),
    .I_rst_n(I_rst_n),
    .push_i (fifo_push),
    .wdata_i(u_d_out),
    .pop_i  (rx_pop),
    .rdata_o(rx_data),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl: uart/requester/consumer models with queue-based scoreboards.
module tb_uart_host_ctrl;

  localparam int WRN_CYC    = 8;
  localparam int RDN_CYC    = 6;
  localparam int TX_TIMEOUT = 60;
  localparam int RXF_DEPTH  = 4;

  logic       clk = 1'b0;
  logic       I_rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       rx_valid, rx_pop = 1'b0;
  logic [7:0] rx_data;
  logic       tx_err, rx_stall, u_wrn, u_rdn;
  logic [7:0] u_d_in;
  logic [7:0] u_d_out = 8'h00;
  logic       u_t_empty = 1'b1, u_r_ready = 1'b0;
  logic [2:0] dbg_tx_state;
  logic [1:0] dbg_rx_state;

  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];     // bytes expected on the uart write port, in order
  logic [7:0] rx_exp_q[$];  // bytes expected out of the RX FIFO, in order
  logic [7:0] q0[$], q1[$]; // pending bytes of each requester
  logic [7:0] tx_seen[$];
  int grant_log[$];
  bit rnd_mode = 1'b0, stuck_te = 1'b0;
  int last_srv = 1, rdy0_cnt = 0, rd_count = 0;
  int wrn_low = 0, rdn_low = 0, te_wait = 0, te_low = 0;

  always #5 clk = ~clk;

  uart_host_ctrl #(
    .WRN_CYC(WRN_CYC), .RDN_CYC(RDN_CYC), .TX_TIMEOUT(TX_TIMEOUT), .RXF_DEPTH(RXF_DEPTH)
  ) dut (
    .clk(clk), .I_rst_n(I_rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
    .tx_err(tx_err), .rx_stall(rx_stall),
    .u_wrn(u_wrn), .u_rdn(u_rdn), .u_d_in(u_d_in), .u_d_out(u_d_out),
    .u_t_empty(u_t_empty), .u_r_ready(u_r_ready),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected @%0t", name, $time);
  endtask

  // Arbitration reference: a tie goes to the requester not served last.
  always @(negedge clk) begin
    if (!I_rst_n) begin
      last_srv = 1;
    end else if (req0_ready || req1_ready) begin
      int got, want;
      if (req0_ready && req1_ready) fail("ready_not_onehot");
      got = req1_ready ? 1 : 0;
      if (req0_valid && req1_valid) want = 1 - last_srv;
      else if (req0_valid)          want = 0;
      else if (req1_valid)          want = 1;
      else                          want = -1;
      check("grant_src", got, want);
      grant_log.push_back(got);
      last_srv = got;
      if (got == 0) begin
        exp_q.push_back(req0_data);
        rdy0_cnt++;
        if (q0.size() > 0) q0.delete(0);
      end else begin
        exp_q.push_back(req1_data);
        if (q1.size() > 0) q1.delete(0);
      end
    end
  end

  // Requester driver: head byte presented while pending, with optional random churn.
  always @(posedge clk) begin
    #1;
    if (rnd_mode && q0.size() > 0 && $urandom_range(0, 7) == 0) q0[0] = 8'($urandom);
    if (rnd_mode && q1.size() > 0 && $urandom_range(0, 7) == 0) q1[0] = 8'($urandom);
    req0_valid = (q0.size() > 0) && !(rnd_mode && $urandom_range(0, 3) == 0);
    req1_valid = (q1.size() > 0) && !(rnd_mode && $urandom_range(0, 3) == 0);
    req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
  end

  // Uart transmit model: wrn monitor plus t_empty response after each write.
  always @(negedge clk) begin
    if (!I_rst_n) begin
      wrn_low = 0; te_wait = 0; te_low = 0; u_t_empty = 1'b1;
    end else begin
      if (!u_wrn) begin
        wrn_low++;
      end else if (wrn_low != 0) begin
        check("wrn_len", wrn_low, WRN_CYC);
        tx_seen.push_back(u_d_in);
        if (exp_q.size() == 0) fail("tx_unexpected_write");
        else check("tx_byte", u_d_in, exp_q.pop_front());
        wrn_low = 0;
        if (!stuck_te) te_wait = 3;
      end
      if (te_wait > 0) begin
        te_wait--;
        if (te_wait == 0) begin u_t_empty = 1'b0; te_low = 6; end
      end else if (te_low > 0) begin
        te_low--;
        if (te_low == 0) u_t_empty = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!I_rst_n) begin
      rdn_low = 0;
    end else if (!u_rdn) begin
      if (rdn_low == 0) rd_count++;
      rdn_low++;
    end else if (rdn_low != 0) begin
      check("rdn_len", rdn_low, RDN_CYC);
      rdn_low = 0;
    end
  end

  // RX scoreboard: every accepted pop must return the oldest byte still expected.
  always @(negedge clk) begin
    if (I_rst_n && rx_pop && rx_valid) begin
      if (rx_exp_q.size() == 0) fail("rx_unexpected_byte");
      else check("rx_byte", rx_data, rx_exp_q.pop_front());
    end
  end

  task automatic rst_assert();
    @(posedge clk); #2;
    I_rst_n = 1'b0; u_r_ready = 1'b0; rx_pop = 1'b0; stuck_te = 1'b0; rnd_mode = 1'b0;
    exp_q.delete(); rx_exp_q.delete(); q0.delete(); q1.delete();
    grant_log.delete(); tx_seen.delete();
  endtask

  task automatic rst_release();
    repeat (3) @(posedge clk);
    #2 I_rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < budget) begin
      @(negedge clk); n++;
    end
    if (q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) fail("tx_drain_timeout");
    repeat (20) @(negedge clk);
  endtask

  task automatic uart_rx_byte(input logic [7:0] b, input int hold);
    int n = 0;
    @(posedge clk); #1;
    u_d_out = b; u_r_ready = 1'b1; rx_exp_q.push_back(b);
    while (u_rdn && n < 2000) begin @(negedge clk); n++; end
    if (u_rdn) fail("rdn_fall_timeout");
    n = 0;
    while (!u_rdn && n < 100) begin @(negedge clk); n++; end
    if (!u_rdn) fail("rdn_rise_timeout");
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 u_r_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    int n = 0;
    while (!rx_valid && n < 2000) begin @(negedge clk); n++; end
    if (!rx_valid) fail("rx_valid_timeout");
    @(posedge clk); #1 rx_pop = 1'b1;
    @(posedge clk); #1 rx_pop = 1'b0;
  endtask

  initial begin
    int rc, n;
    logic [7:0] b;
    logic [7:0] t2_bytes[4];
    logic [7:0] stall_bytes[5];
    t2_bytes    = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
    stall_bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

    // Reset with req0 already requesting.
    rst_assert();
    q0.push_back(8'h55);
    repeat (2) @(negedge clk);
    check("rst_u_wrn", u_wrn, 1);
    check("rst_u_rdn", u_rdn, 1);
    check("rst_u_d_in", u_d_in, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_rx_stall", rx_stall, 0);
    rc = rdy0_cnt;
    rst_release();
    wait_tx_drain(500);
    check("t1_ready0_pulses", rdy0_cnt - rc, 1);
    check("t1_d_in_held", u_d_in, 8'h55);

    // Pop on an empty FIFO is ignored.
    @(posedge clk); #1 rx_pop = 1'b1;
    @(posedge clk); #1 rx_pop = 1'b0;
    @(negedge clk);
    check("empty_pop_valid", rx_valid, 0);

    // Sustained dual requests alternate starting with req0.
    rst_assert();
    q0.push_back(8'hA1); q0.push_back(8'hA1);
    q1.push_back(8'hB2); q1.push_back(8'hB2);
    rst_release();
    wait_tx_drain(1000);
    check("t2_grants", grant_log.size(), 4);
    check("t2_writes", tx_seen.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size() && i < tx_seen.size(); i++) begin
      check("t2_order", grant_log[i], i % 2);
      check("t2_d_in_seq", tx_seen[i], t2_bytes[i]);
    end
    check("t2_no_err", tx_err, 0);

    // t_empty stuck high: timeout, sticky error, next request still served.
    rst_assert();
    rst_release();
    stuck_te = 1'b1;
    q0.push_back(8'h3C);
    n = 0;
    while (u_wrn && n < 100) begin @(negedge clk); n++; end
    while (!u_wrn && n < 200) begin @(negedge clk); n++; end
    if (!u_wrn || n >= 200) fail("t3_write_timeout");
    n = 0;
    while (!tx_err && n < 200) begin @(negedge clk); n++; end
    check("t3_timeout_cycles", n, TX_TIMEOUT);
    check("t3_back_to_idle", dbg_tx_state, 32'(uart_pkg::TX_IDLE));
    stuck_te = 1'b0;
    q1.push_back(8'hC3);
    wait_tx_drain(1000);
    check("t3_next_served", tx_seen.size(), 2);
    check("t3_err_sticky", tx_err, 1);

    // Five bytes with no pops: four fill the FIFO, the fifth stalls.
    rst_assert();
    rst_release();
    rc = rd_count;
    for (int i = 0; i < 4; i++) uart_rx_byte(stall_bytes[i], 2);
    check("t4_reads_4", rd_count - rc, 4);
    @(posedge clk); #1;
    u_d_out = stall_bytes[4]; u_r_ready = 1'b1; rx_exp_q.push_back(stall_bytes[4]);
    repeat (20) @(negedge clk);
    check("t4_stall_set", rx_stall, 1);
    check("t4_no_fifth_read", rd_count - rc, 4);
    check("t4_head", rx_data, 8'h10);
    @(posedge clk); #1 rx_pop = 1'b1;
    @(posedge clk); #1 rx_pop = 1'b0;
    @(negedge clk);
    check("t4_stall_clear", rx_stall, 0);
    n = 0;
    while (u_rdn && n < 50) begin @(negedge clk); n++; end
    while (!u_rdn && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 u_r_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_fifth_read", rd_count - rc, 5);
    for (int i = 0; i < 4; i++) pop_one();
    @(negedge clk);
    check("t4_drained", rx_valid, 0);
    check("t4_exp_empty", rx_exp_q.size(), 0);

    // r_ready held long after a read: still a single capture.
    rc = rd_count;
    uart_rx_byte(8'h5A, 3000);
    check("t5_one_read", rd_count - rc, 1);
    pop_one();
    repeat (2) @(negedge clk);
    check("t5_one_push", rx_valid, 0);

    // Reset asserted while both strobes are low.
    rst_assert();
    rst_release();
    @(posedge clk); #1;
    u_d_out = 8'h77; u_r_ready = 1'b1; rx_exp_q.push_back(8'h77);
    q0.push_back(8'h99);
    n = 0;
    while (!(!u_wrn && !u_rdn) && n < 50) begin @(negedge clk); n++; end
    if (u_wrn || u_rdn) fail("t6_strobes_not_low");
    check("t6_rx_valid_pre", rx_valid, 1);
    #1 I_rst_n = 1'b0;
    #1;
    check("t6_wrn_high", u_wrn, 1);
    check("t6_rdn_high", u_rdn, 1);
    check("t6_rx_valid_clr", rx_valid, 0);
    rst_assert();
    rst_release();

    // Randomized transmit with withdrawals and data churn.
    rnd_mode = 1'b1;
    for (int i = 0; i < 6; i++) q0.push_back(8'($urandom));
    repeat ($urandom_range(0, 30)) @(negedge clk);
    for (int i = 0; i < 6; i++) q1.push_back(8'($urandom));
    wait_tx_drain(5000);
    rnd_mode = 1'b0;
    check("t7_no_err", tx_err, 0);

    // Randomized receive against a random-rate consumer.
    fork
      for (int i = 0; i < 10; i++) begin
        b = 8'($urandom);
        uart_rx_byte(b, $urandom_range(0, 5));
      end
      for (int j = 0; j < 10; j++) begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
        pop_one();
      end
    join
    repeat (4) @(negedge clk);
    check("t8_exp_empty", rx_exp_q.size(), 0);
    check("t8_fifo_empty", rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    fail("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
